seg7_scan: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It sits directly downstream of the switch/button logic in `top`: it latches a 16-bit hex value on a load strobe and scans it onto `SEG`/`AN`. It adds a per-digit anti-ghosting blank window, decimal-point control and optional leading-zero suppression. All outputs are registered.

---
 rtl/seg7_pkg.sv | 10 +
 rtl/seg7_decode.sv | 8 +
 rtl/seg7_scan.sv | 74 +++++++
 tb/tb_seg7_scan.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment table for the 7-segment scanner
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low {g..a} segment pattern
module seg7_decode (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    import seg7_pkg::*;
    assign o_seg = SEG_TABLE[i_nib];
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit common-anode display scanner with blanking, dp and zero suppression
module seg7_scan #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLANK_CYC = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp,
    input  logic        lz_en,
    output logic [7:0]  SEG,
    output logic [3:0]  AN
);
    import seg7_pkg::*;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_idx;
    logic [15:0]           r_val;
    logic [NUM_DIGITS-1:0] r_dp;
    logic                  r_lz;
    logic [1:0]            w_next;
    logic [NUM_DIGITS-1:0] w_sup;
    logic                  w_off;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg;
    assign w_next = (r_idx == DIG0) ? DIG1 : (r_idx == DIG1) ? DIG2 : (r_idx == DIG2) ? DIG3 : DIG0;
    assign w_sup  = {r_lz & ~|r_val[15:12], r_lz & ~|r_val[15:8], r_lz & ~|r_val[15:4], 1'b0};
    assign w_off  = (32'(r_cnt) < BLANK_CYC) | w_sup[r_idx];
    assign w_nib  = r_val[4*r_idx +: 4];
    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );
    // slot counter and digit FSM; a slot ends at LAST and advances the digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= DIG0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_idx <= w_next;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    // shadow registers captured on load without disturbing the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= '0;
            r_dp  <= '0;
            r_lz  <= 1'b0;
        end else if (load) begin
            r_val <= value;
            r_dp  <= dp;
            r_lz  <= lz_en;
        end
    end
    // registered outputs: dark during blank window or for suppressed digits
    always_ff @(posedge clk) begin
        if (rst) begin
            SEG <= SEG_OFF;
            AN  <= AN_OFF;
        end else begin
            SEG <= w_off ? SEG_OFF : {~r_dp[r_idx], w_seg};
            AN  <= w_off ? AN_OFF : ~(4'b0001 << r_idx);
        end
    end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed and random checks of seg7_scan against a time-based reference model
module tb_seg7_scan;
    localparam int SD = 4;
    localparam int BC = 1;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [7:0]  SEG;
    logic [3:0]  AN;
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_t = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    logic [7:0]  e_seg = 8'hFF;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [11:0] exp_digits [4];

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .dp    (dp),
        .lz_en (lz_en),
        .SEG   (SEG),
        .AN    (AN)
    );

    // Reference: scan position is elapsed cycles since reset; output reflects state before the edge
    task automatic model_edge();
        int c, d;
        logic [3:0] nib;
        if (rst) begin
            e_seg = 8'hFF; e_an = 4'hF;
            m_t = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
        end else begin
            c = m_t % SD;
            d = (m_t / SD) % 4;
            nib = 4'(m_val >> (4 * d));
            if (c < BC || (m_lz && d > 0 && (m_val >> (4 * d)) == 16'd0)) begin
                e_seg = 8'hFF; e_an = 4'hF;
            end else begin
                e_an = 4'hF;
                e_an[d] = 1'b0;
                e_seg = {~m_dp[d], tbl[nib]};
            end
            m_t++;
            if (load) begin
                m_val = value; m_dp = dp; m_lz = lz_en;
            end
        end
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, {SEG, AN}, {e_seg, e_an});
    endtask

    task automatic start(input logic [15:0] v, input logic [3:0] d, input logic lz);
        rst = 1'b1; load = 1'b0;
        cyc("restart_rst");
        rst = 1'b0; load = 1'b1; value = v; dp = d; lz_en = lz;
        cyc("restart_load");
        load = 1'b0;
    endtask

    task automatic scan_frame(input string tag);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(tag);
                check({tag, "_lit"}, {SEG, AN}, exp_digits[g]);
            end
            cyc(tag);
            check({tag, "_blank"}, {SEG, AN}, 12'hFFF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp = 4'hF; lz_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc("reset");
            check("reset_const", {SEG, AN}, 12'hFFF);
        end
        rst = 1'b0; load = 1'b0;
        cyc("post_reset");
        check("post_reset_blank", {SEG, AN}, 12'hFFF);
        cyc("post_reset_dig0");
        check("post_reset_dig0_const", {SEG, AN}, 12'hC0E);

        start(16'hABCD, 4'b0000, 1'b0);
        exp_digits = '{12'hA1E, 12'hC6D, 12'h83B, 12'h887};
        scan_frame("basic");
        cyc("basic_wrap");
        check("basic_wrap_const", {SEG, AN}, 12'hA1E);

        start(16'h0050, 4'b0000, 1'b1);
        exp_digits = '{12'hC0E, 12'h92D, 12'hFFF, 12'hFFF};
        scan_frame("lz0050");

        start(16'h0000, 4'b0000, 1'b1);
        exp_digits = '{12'hC0E, 12'hFFF, 12'hFFF, 12'hFFF};
        scan_frame("lz0000");

        start(16'h1234, 4'b0100, 1'b0);
        exp_digits = '{12'h99E, 12'hB0D, 12'h24B, 12'hF97};
        scan_frame("dp");

        start(16'h0000, 4'b0000, 1'b0);
        for (int k = 0; k < 5; k++) cyc("midload_pre");
        load = 1'b1; value = 16'h1111;
        cyc("midload_capture");
        check("midload_capture_const", {SEG, AN}, 12'hC0D);
        load = 1'b0;
        cyc("midload_show");
        check("midload_show_const", {SEG, AN}, 12'hF9D);
        cyc("midload_blank");
        check("midload_blank_const", {SEG, AN}, 12'hFFF);
        cyc("midload_dig2");
        check("midload_dig2_const", {SEG, AN}, 12'hF9B);
        rst = 1'b1;
        cyc("rst_dig2");
        check("rst_dig2_const", {SEG, AN}, 12'hFFF);
        rst = 1'b0;
        cyc("rst_dig2_release");
        check("rst_dig2_release_const", {SEG, AN}, 12'hFFF);
        cyc("rst_dig2_restart");
        check("rst_dig2_restart_const", {SEG, AN}, 12'hC0E);

        for (int k = 0; k < 600; k++) begin
            logic [15:0] mask;
            mask = '0;
            for (int n = 0; n < 4; n++) if ($urandom_range(1, 0) == 1) mask[4*n +: 4] = 4'hF;
            rst   = ($urandom_range(63, 0) == 0);
            load  = ($urandom_range(5, 0) == 0);
            value = 16'($urandom) & mask;
            dp    = 4'($urandom);
            lz_en = 1'($urandom);
            cyc("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
